// File: rtl/dpram_pkg.sv
// rtl/dpram_pkg.sv - shared types, constants and byte helpers for dpram_sync
//
// Purpose: FSM state enum, read-during-write mode constants, and byte-merge /
//          byte-parity helpers. The helpers work on words up to MAX_DATA_WIDTH bits.
//          Callers zero-extend their words on the way in and truncate the result
//          on the way out.
// Ports:   none (package)
package dpram_pkg;

  typedef enum logic {INIT, READY} t_dpram_state;

  localparam int RDW_READ_FIRST  = 0;
  localparam int RDW_WRITE_FIRST = 1;

  localparam int MAX_DATA_WIDTH = 256;
  localparam int MAX_BYTES      = MAX_DATA_WIDTH / 8;

  typedef logic [MAX_DATA_WIDTH-1:0] t_word_max;
  typedef logic [MAX_BYTES-1:0]      t_be_max;

  // Byte i of the result comes from new_word when be[i] is set, else from old_word.
  function automatic t_word_max be_merge(input t_word_max old_word,
                                         input t_word_max new_word,
                                         input t_be_max   be);
    t_word_max r;
    r = old_word;
    for (int i = 0; i < MAX_BYTES; i++) begin
      if (be[i]) r[i*8 +: 8] = new_word[i*8 +: 8];
    end
    return r;
  endfunction

  // Even parity per byte: the stored bit makes each 9-bit group have an even 1-count.
  function automatic t_be_max byte_parity(input t_word_max word);
    t_be_max r;
    for (int i = 0; i < MAX_BYTES; i++) begin
      r[i] = ^word[i*8 +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/dpram_sync_if.sv
// rtl/dpram_sync_if.sv - one RAM access port (request + registered response)
//
// Purpose: bundles one port's request and response signals.
// Ports:   en, wren, be, address, data (requester -> RAM);
//          q, q_valid, parity_err (RAM -> requester).
//          master = requester side, slave = RAM side.
interface dpram_sync_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10
);
  logic                    en;
  logic                    wren;
  logic [DATA_WIDTH/8-1:0] be;
  logic [ADDR_WIDTH-1:0]   address;
  logic [DATA_WIDTH-1:0]   data;
  logic [DATA_WIDTH-1:0]   q;
  logic                    q_valid;
  logic                    parity_err;

  modport master (output en, wren, be, address, data,
                  input  q, q_valid, parity_err);
  modport slave  (input  en, wren, be, address, data,
                  output q, q_valid, parity_err);
endinterface

// File: rtl/dpram_init_seq.sv
// rtl/dpram_init_seq.sv - clear-on-reset sequencer for dpram_sync
//
// Purpose: after reset, walks a counter over every word (one per cycle) and
//          requests a zero write. It then parks in READY until the next reset.
// Ports:   clock, reset_n (sync active-low);
//          init_done (state is READY);
//          init_we / init_idx (clear-write strobe and word index).
module dpram_init_seq
  import dpram_pkg::*;
#(
  parameter int DEPTH = 1024,
  parameter int IDX_W = 10
) (
  input  logic             clock,
  input  logic             reset_n,
  output logic             init_done,
  output logic             init_we,
  output logic [IDX_W-1:0] init_idx
);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

  t_dpram_state     state_q, state_d;
  logic [IDX_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q <= INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    init_we = 1'b0;
    case (state_q)
      INIT: begin
        init_we = 1'b1;
        if (cnt_q == LAST_IDX) begin
          state_d = READY;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      READY:   state_d = READY;
      default: state_d = INIT;
    endcase
  end

  assign init_done = (state_q == READY);
  assign init_idx  = cnt_q;

endmodule

// File: rtl/dpram_sync.sv
// rtl/dpram_sync.sv - single-clock true dual-port RAM with byte enables
//
// Purpose: two-port synchronous RAM with per-byte writes and a selectable
//          read-during-write mode (RDW_MODE). It reports same-address dual
//          writes and clears itself after reset. Optional per-byte even parity
//          is enabled by defining DPRAM_PARITY_EN.
// Ports:   clock, reset_n (sync active-low);
//          init_done (clear sequence finished, requests accepted);
//          collision (both ports wrote the same word last cycle);
//          port_a, port_b (dpram_sync_if.slave: en/wren/be/address/data in,
//          q/q_valid/parity_err out).
module dpram_sync
  import dpram_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10,
  parameter int DEPTH      = 1024,
  parameter int RDW_MODE   = 0
) (
  input  logic        clock,
  input  logic        reset_n,
  output logic        init_done,
  output logic        collision,
  dpram_sync_if.slave port_a,
  dpram_sync_if.slave port_b
);
  localparam int                  NB          = DATA_WIDTH / 8;
  localparam int                  IDX_W       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_WIDTH:0] DEPTH_L     = (ADDR_WIDTH + 1)'(DEPTH);
  localparam bit                  WRITE_FIRST = (RDW_MODE == RDW_WRITE_FIRST);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic             init_we;
  logic [IDX_W-1:0] init_idx;

  dpram_init_seq #(
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_init_seq (
    .clock     (clock),
    .reset_n   (reset_n),
    .init_done (init_done),
    .init_we   (init_we),
    .init_idx  (init_idx)
  );

  // Request decode: nothing is accepted until the clear sequence finishes.
  logic             in_range_a, in_range_b;
  logic [IDX_W-1:0] idx_a, idx_b;
  logic             rd_a, rd_b, wr_a, wr_b, same_addr;

  assign in_range_a = {1'b0, port_a.address} < DEPTH_L;
  assign in_range_b = {1'b0, port_b.address} < DEPTH_L;
  assign idx_a      = port_a.address[IDX_W-1:0];
  assign idx_b      = port_b.address[IDX_W-1:0];
  assign rd_a       = init_done & port_a.en & ~port_a.wren;
  assign rd_b       = init_done & port_b.en & ~port_b.wren;
  assign wr_a       = init_done & port_a.en & port_a.wren & in_range_a;
  assign wr_b       = init_done & port_b.en & port_b.wren & in_range_b;
  assign same_addr  = (port_a.address == port_b.address);

  // Pre-write contents; out-of-range reads see zero.
  logic [DATA_WIDTH-1:0] old_a, old_b;
  assign old_a = in_range_a ? mem_q[idx_a] : '0;
  assign old_b = in_range_b ? mem_q[idx_b] : '0;

  // On a dual write to one word, B's merge starts from A's result so that
  // B wins overlapping bytes and A's other bytes survive.
  logic [DATA_WIDTH-1:0] wr_word_a, wr_word_b;
  logic                  collision_d, collision_q;
  assign collision_d = wr_a & wr_b & same_addr;
  assign wr_word_a   = DATA_WIDTH'(be_merge(t_word_max'(old_a), t_word_max'(port_a.data),
                                            t_be_max'(port_a.be)));
  assign wr_word_b   = DATA_WIDTH'(be_merge(t_word_max'(collision_d ? wr_word_a : old_b),
                                            t_word_max'(port_b.data), t_be_max'(port_b.be)));

  // Cross-port read-during-write: write-first readers see the other port's bytes.
  logic [DATA_WIDTH-1:0] rd_data_a, rd_data_b;
  always_comb begin
    rd_data_a = old_a;
    rd_data_b = old_b;
    if (WRITE_FIRST && wr_b && same_addr)
      rd_data_a = DATA_WIDTH'(be_merge(t_word_max'(old_a), t_word_max'(port_b.data),
                                       t_be_max'(port_b.be)));
    if (WRITE_FIRST && wr_a && same_addr)
      rd_data_b = DATA_WIDTH'(be_merge(t_word_max'(old_b), t_word_max'(port_a.data),
                                       t_be_max'(port_a.be)));
  end

  logic [DATA_WIDTH-1:0] q_a_q, q_a_d, q_b_q, q_b_d;
  logic                  q_valid_a_q, q_valid_a_d, q_valid_b_q, q_valid_b_d;

  always_comb begin
    q_a_d       = rd_a ? rd_data_a : q_a_q;
    q_b_d       = rd_b ? rd_data_b : q_b_q;
    q_valid_a_d = rd_a;
    q_valid_b_d = rd_b;
  end

`ifdef DPRAM_PARITY_EN
  logic [NB-1:0] par_q [DEPTH];
  logic          perr_a_q, perr_a_d, perr_b_q, perr_b_d;

  // Checks the stored word against its stored parity, independent of RDW merging.
  always_comb begin
    perr_a_d = rd_a & in_range_a &
               (NB'(byte_parity(t_word_max'(old_a))) != par_q[idx_a]);
    perr_b_d = rd_b & in_range_b &
               (NB'(byte_parity(t_word_max'(old_b))) != par_q[idx_b]);
  end
`endif

  // Storage: the clear sequence owns the array until init_done; a later B write
  // to the same word overrides A's, and wr_word_b already folds A's bytes in.
  always_ff @(posedge clock) begin
    if (reset_n) begin
      if (init_we) begin
        mem_q[init_idx] <= '0;
`ifdef DPRAM_PARITY_EN
        par_q[init_idx] <= '0;
`endif
      end else begin
        if (wr_a) begin
          mem_q[idx_a] <= wr_word_a;
`ifdef DPRAM_PARITY_EN
          par_q[idx_a] <= NB'(byte_parity(t_word_max'(wr_word_a)));
`endif
        end
        if (wr_b) begin
          mem_q[idx_b] <= wr_word_b;
`ifdef DPRAM_PARITY_EN
          par_q[idx_b] <= NB'(byte_parity(t_word_max'(wr_word_b)));
`endif
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      q_a_q       <= '0;
      q_b_q       <= '0;
      q_valid_a_q <= 1'b0;
      q_valid_b_q <= 1'b0;
      collision_q <= 1'b0;
`ifdef DPRAM_PARITY_EN
      perr_a_q    <= 1'b0;
      perr_b_q    <= 1'b0;
`endif
    end else begin
      q_a_q       <= q_a_d;
      q_b_q       <= q_b_d;
      q_valid_a_q <= q_valid_a_d;
      q_valid_b_q <= q_valid_b_d;
      collision_q <= collision_d;
`ifdef DPRAM_PARITY_EN
      perr_a_q    <= perr_a_d;
      perr_b_q    <= perr_b_d;
`endif
    end
  end

  assign port_a.q       = q_a_q;
  assign port_b.q       = q_b_q;
  assign port_a.q_valid = q_valid_a_q;
  assign port_b.q_valid = q_valid_b_q;
  assign collision      = collision_q;
`ifdef DPRAM_PARITY_EN
  assign port_a.parity_err = perr_a_q;
  assign port_b.parity_err = perr_b_q;
`else
  assign port_a.parity_err = 1'b0;
  assign port_b.parity_err = 1'b0;
`endif

endmodule
